// File: rtl/debounce_pkg.sv
// Shared types and constants for the multi-channel key debouncer.
// Holds the per-channel FSM encoding and the synchroniser depth.
package debounce_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // True when value is representable as a non-zero unsigned number of the given width.
  function automatic bit fits_nonzero(input longint value, input int width);
    return (value >= 1) && (value <= ((longint'(1) << width) - 1));
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced key: 2-FF synchroniser, hysteresis FSM, hold counter and
// registered single-cycle press / release / long-press pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int THRESHOLD  = 255,
  parameter int LONG_TICKS = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic key_raw,
  output logic key_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam logic             RELEASED_LEVEL = logic'(ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] THR            = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] LONG           = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] ONE            = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pressed;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cnt_inc, hold_inc;
  logic             press_d, release_d, long_d;

  // Synchroniser keeps running regardless of tick; it resets to the released level.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RELEASED_LEVEL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
    end
  end

  assign pressed  = sync_q[SYNC_STAGES-1] ^ RELEASED_LEVEL;
  assign cnt_inc  = cnt_q + ONE;
  assign hold_inc = hold_q + ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hold_q        <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (pressed) begin
            if (THRESHOLD == 1) begin
              state_d = PRESSED;
              cnt_d   = '0;
              press_d = 1'b1;
            end else begin
              state_d = PRESS_WAIT;
              cnt_d   = ONE;
            end
          end
        end

        PRESS_WAIT: begin
          if (!pressed) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_inc == THR) begin
            state_d = PRESSED;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        PRESSED: begin
          if (pressed) begin
            if (hold_q != LONG) begin
              hold_d = hold_inc;
              long_d = (hold_inc == LONG);
            end
          end else if (THRESHOLD == 1) begin
            state_d   = IDLE;
            cnt_d     = '0;
            hold_d    = '0;
            release_d = 1'b1;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = ONE;
          end
        end

        RELEASE_WAIT: begin
          if (pressed) begin
            // Bounce back to pressed: the hold count survives and keeps advancing.
            state_d = PRESSED;
            cnt_d   = '0;
            if (hold_q != LONG) begin
              hold_d = hold_inc;
              long_d = (hold_inc == LONG);
            end
          end else if (cnt_inc == THR) begin
            state_d   = IDLE;
            cnt_d     = '0;
            hold_d    = '0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          hold_d  = '0;
        end
      endcase
    end
  end

  // Hysteresis: the debounced level only flips once a wait state completes.
  assign key_state = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent key debouncers sharing one sample tick.
// Parameter legality is checked at elaboration.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 16,
  parameter int THRESHOLD  = 255,
  parameter int LONG_TICKS = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic [CHANNELS-1:0] key_raw,
  output logic [CHANNELS-1:0] key_state,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] long_pulse
);

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("debounce_bank: CHANNELS must be 1..32");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("debounce_bank: CNT_W must be 1..32");
  end
  if (!fits_nonzero(longint'(THRESHOLD), CNT_W)) begin : g_bad_threshold
    $error("debounce_bank: THRESHOLD must be 1..2^CNT_W-1");
  end
  if (!fits_nonzero(longint'(LONG_TICKS), CNT_W)) begin : g_bad_long
    $error("debounce_bank: LONG_TICKS must be 1..2^CNT_W-1");
  end
  if (ACTIVE_LOW != 0 && ACTIVE_LOW != 1) begin : g_bad_polarity
    $error("debounce_bank: ACTIVE_LOW must be 0 or 1");
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_channel
    debounce_channel #(
      .CNT_W      (CNT_W),
      .THRESHOLD  (THRESHOLD),
      .LONG_TICKS (LONG_TICKS),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_channel (
      .clk           (clk),
      .rst           (rst),
      .tick          (tick),
      .key_raw       (key_raw[ch]),
      .key_state     (key_state[ch]),
      .press_pulse   (press_pulse[ch]),
      .release_pulse (release_pulse[ch]),
      .long_pulse    (long_pulse[ch])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank (2 channels, threshold 4, long press 8).
// A run-length reference model fills a scoreboard each cycle; scenario timing is checked directly.
module tb_debounce_bank;

  localparam int CH   = 2;
  localparam int THR  = 4;
  localparam int LONG = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b1;
  logic [CH-1:0] key_raw = '1;
  logic [CH-1:0] key_state, press_pulse, release_pulse, long_pulse;

  debounce_bank #(
    .CHANNELS   (CH),
    .CNT_W      (16),
    .THRESHOLD  (THR),
    .LONG_TICKS (LONG),
    .ACTIVE_LOW (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .key_raw       (key_raw),
    .key_state     (key_state),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] ks;
    logic [CH-1:0] pp;
    logic [CH-1:0] rp;
    logic [CH-1:0] lp;
  } obs_t;

  obs_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  string scen = "reset";

  // Reference model: debounced level flips after THR consecutive disagreeing ticks.
  logic [CH-1:0] m_s1, m_s2, m_deb;
  int m_run [CH];
  int m_hold[CH];

  int press_n[CH], rel_n[CH], long_n[CH];
  int press_at[CH], rel_at[CH], long_at[CH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1  = '1;
    m_s2  = '1;
    m_deb = '0;
    for (int c = 0; c < CH; c++) begin
      m_run[c]  = 0;
      m_hold[c] = 0;
    end
  endtask

  task automatic clear_stats();
    for (int c = 0; c < CH; c++) begin
      press_n[c] = 0; rel_n[c] = 0; long_n[c] = 0;
      press_at[c] = -1; rel_at[c] = -1; long_at[c] = -1;
    end
  endtask

  // Predict the outputs that follow the coming clock edge.
  task automatic model_step(output obs_t e);
    logic s;
    e = '0;
    if (rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < CH; c++) begin
        s = ~m_s2[c];
        if (tick) begin
          if (s != m_deb[c]) begin
            m_run[c]++;
            if (m_run[c] == THR) begin
              m_run[c] = 0;
              m_deb[c] = s;
              if (s) e.pp[c] = 1'b1;
              else begin
                e.rp[c] = 1'b1;
                m_hold[c] = 0;
              end
            end
          end else begin
            m_run[c] = 0;
            if (m_deb[c] && m_hold[c] < LONG) begin
              m_hold[c]++;
              if (m_hold[c] == LONG) e.lp[c] = 1'b1;
            end
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = key_raw;
    end
    e.ks = m_deb;
  endtask

  // One clock: drive inputs, push prediction, sample #1 after the edge and compare.
  task automatic cycle(input logic [CH-1:0] raw, input logic t, input logic r);
    obs_t e, got;
    key_raw = raw;
    tick    = t;
    rst     = r;
    model_step(e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got = {key_state, press_pulse, release_pulse, long_pulse};
    e   = exp_q.pop_front();
    check(scen, 32'(got), 32'(e));
    for (int c = 0; c < CH; c++) begin
      if (press_pulse[c])   begin press_n[c]++; press_at[c] = cyc; end
      if (release_pulse[c]) begin rel_n[c]++;   rel_at[c]   = cyc; end
      if (long_pulse[c])    begin long_n[c]++;  long_at[c]  = cyc; end
    end
  endtask

  task automatic run(input logic [CH-1:0] raw, input int n);
    for (int i = 0; i < n; i++) cycle(raw, 1'b1, 1'b0);
  endtask

  int start;

  initial begin
    model_reset();
    clear_stats();

    // Reset state
    #2;
    check("reset_outputs", 32'({key_state, press_pulse, release_pulse, long_pulse}), 32'h0);
    for (int i = 0; i < 3; i++) cycle(2'b11, 1'b1, 1'b1);
    cycle(2'b11, 1'b1, 1'b0);
    run(2'b11, 3);

    // Clean press on channel 0, channel 1 quiet
    scen = "clean_press";
    clear_stats();
    start = cyc;
    run(2'b10, 10);
    check("clean_press_count0", 32'(press_n[0]), 32'd1);
    check("clean_press_count1", 32'(press_n[1]), 32'd0);
    check("clean_press_latency", 32'(press_at[0] - start), 32'd6);
    start = cyc;
    run(2'b11, 10);
    check("clean_release_latency", 32'(rel_at[0] - start), 32'd6);

    // Bounce on press: low 3, high 1, then steady low
    scen = "bounce";
    clear_stats();
    run(2'b10, 3);
    run(2'b11, 1);
    start = cyc;
    run(2'b10, 12);
    check("bounce_press_count", 32'(press_n[0]), 32'd1);
    check("bounce_press_latency", 32'(press_at[0] - start), 32'd6);
    run(2'b11, 10);

    // Long press and release
    scen = "long_press";
    clear_stats();
    run(2'b10, 20);
    check("long_count", 32'(long_n[0]), 32'd1);
    check("long_after_press", 32'(long_at[0] - press_at[0]), 32'd8);
    start = cyc;
    run(2'b11, 10);
    check("long_release_latency", 32'(rel_at[0] - start), 32'd6);
    check("long_release_count", 32'(rel_n[0]), 32'd1);

    // Tick every 4th clock
    scen = "tick_gate";
    clear_stats();
    start = cyc;
    for (int i = 0; i < 30; i++) cycle(2'b10, 1'((i % 4) == 3), 1'b0);
    check("tick_press_latency", 32'(press_at[0] - start), 32'd16);
    check("tick_press_count", 32'(press_n[0]), 32'd1);
    for (int i = 0; i < 30; i++) cycle(2'b11, 1'((i % 4) == 3), 1'b0);
    check("tick_release_count", 32'(rel_n[0]), 32'd1);

    // Reset while pressed
    scen = "reset_mid";
    clear_stats();
    run(2'b10, 8);
    check("pre_reset_state", 32'(key_state), 32'h1);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", 32'({key_state, press_pulse, release_pulse, long_pulse}), 32'h0);
    for (int i = 0; i < 3; i++) cycle(2'b10, 1'b1, 1'b1);
    clear_stats();
    start = cyc;
    for (int i = 0; i < 10; i++) cycle(2'b10, 1'b1, 1'b0);
    check("reset_repress_latency", 32'(press_at[0] - start), 32'd6);
    check("reset_no_release", 32'(rel_n[0]), 32'd0);
    run(2'b11, 10);

    // Both channels pressed together
    scen = "simultaneous";
    clear_stats();
    run(2'b00, 10);
    check("sim_press_count0", 32'(press_n[0]), 32'd1);
    check("sim_press_count1", 32'(press_n[1]), 32'd1);
    check("sim_same_cycle", 32'(press_at[1]), 32'(press_at[0]));
    run(2'b11, 10);
    check("sim_release_count1", 32'(rel_n[1]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
